// File: rtl/riscv_parcel_queue.sv
// Halfword instruction queue between fetch and pre-decode: compacts fetch parcels,
// re-aligns 16/32-bit instructions and tags them with PC and fetch exceptions.
module riscv_parcel_queue #(
    parameter int unsigned      XLEN        = 32,
    parameter int unsigned      PARCEL_SIZE = 32,
    parameter int unsigned      DEPTH       = 8,
    parameter bit               HAS_RVC     = 1'b1,
    parameter logic [XLEN-1:0]  PC_INIT     = 'h200
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [PARCEL_SIZE-1:0]     parcel,
    input  logic [XLEN-1:0]            parcel_pc,
    input  logic [PARCEL_SIZE/16-1:0]  parcel_valid,
    input  logic                       parcel_misaligned,
    input  logic                       parcel_page_fault,
    output logic                       push_ready,
    output logic [31:0]                instr,
    output logic [XLEN-1:0]            instr_pc,
    output logic                       instr_is16,
    output logic [1:0]                 instr_exception,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned LANES  = PARCEL_SIZE / 16;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    function automatic logic [CNT_W-1:0] lane_count(input logic [LANES-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < LANES; i++) n = n + CNT_W'(v[i]);
        return n;
    endfunction

    function automatic logic [LANE_W-1:0] first_lane(input logic [LANES-1:0] v);
        logic [LANE_W-1:0] f;
        f = '0;
        for (int i = LANES - 1; i >= 0; i--) if (v[i]) f = LANE_W'(i);
        return f;
    endfunction

    logic [15:0]       mem_data [DEPTH];
    logic [1:0]        mem_exc  [DEPTH];

    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_nx1;
    logic [15:0]       head_data, next_data;
    logic [1:0]        head_exc, next_exc;
    logic              head_is16, exc_short, instr_two;
    logic [CNT_W-1:0]  head_sz, pop_sz, pushed, count_after_pop, free_slots;
    logic [LANE_W-1:0] first;
    logic              push_en, pop_en;
    logic [XLEN-1:0]   push_pc;
    logic [PTR_W-1:0]  lane_slot [LANES];

    assign rd_ptr_nx1 = rd_ptr + PTR_W'(1);
    assign head_data  = mem_data[rd_ptr];
    assign next_data  = mem_data[rd_ptr_nx1];
    assign head_exc   = mem_exc[rd_ptr];
    assign next_exc   = mem_exc[rd_ptr_nx1];

    // A faulting lone halfword issues on its own so the exception is never stuck
    // waiting for an upper half that fetch will not deliver.
    assign head_is16  = HAS_RVC && (head_data[1:0] != 2'b11);
    assign exc_short  = (count == CNT_W'(1)) && (head_exc != 2'b00);
    assign instr_two  = !head_is16 && !exc_short;
    assign head_sz    = instr_two ? CNT_W'(2) : CNT_W'(1);

    assign instr_valid     = (count != '0) && (count >= head_sz);
    assign instr_is16      = !instr_two;
    assign instr           = instr_two ? {next_data, head_data} : {16'h0000, head_data};
    assign instr_exception = !instr_valid ? 2'b00
                           : (instr_two ? (head_exc | next_exc) : head_exc);

    assign free_slots = CNT_W'(DEPTH) - count;
    assign push_ready = free_slots >= CNT_W'(LANES);

    assign pushed          = lane_count(parcel_valid);
    assign first           = first_lane(parcel_valid);
    assign push_en         = !flush && push_ready && (parcel_valid != '0);
    assign pop_en          = !flush && instr_valid && instr_ready;
    assign pop_sz          = pop_en ? head_sz : '0;
    assign count_after_pop = count - pop_sz;
    assign push_pc         = parcel_pc + XLEN'({first, 1'b0});

    // Valid lanes form a contiguous run, so lane i lands (i - first) slots past wr_ptr.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_slot[i] = wr_ptr + PTR_W'(i) - PTR_W'(first);
        end
    end

    always_ff @(posedge clk) begin
        if (push_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (parcel_valid[i]) begin
                    mem_data[lane_slot[i]] <= parcel[16*i +: 16];
                    mem_exc[lane_slot[i]]  <= {parcel_page_fault, parcel_misaligned};
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            instr_pc <= PC_INIT;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + PTR_W'(pop_sz);
            wr_ptr <= wr_ptr + (push_en ? PTR_W'(pushed) : '0);
            count  <= count_after_pop + (push_en ? pushed : '0);
            // A push that lands in an empty (or just-drained) queue starts a new stream.
            if (push_en && (count_after_pop == '0)) begin
                instr_pc <= push_pc;
            end else if (pop_en) begin
                instr_pc <= instr_pc + XLEN'({pop_sz, 1'b0});
            end
        end
    end

endmodule
